// File: rtl/wmem_pkg.sv
// Shared types and default geometry for the streaming weight memory.
package wmem_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ROW_NUM_DEF    = 6;
  localparam int ADDR_WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int row_width(input int dw, input int rn);
    return dw * rn;
  endfunction

endpackage

// File: rtl/wmem_ram.sv
// Simple dual-port row RAM: one write port, one enabled synchronous read port.
// Contents are not reset; a same-address read and write returns the old row.
module wmem_ram #(
  parameter int WIDTH = 48,
  parameter int AW    = 7,
  parameter int DEPTH = 1 << AW
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
    if (i_rd_en) rd_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_q;

endmodule

// File: rtl/wmem_stream.sv
// Weight memory with a burst read sequencer feeding the PE array over
// valid/ready, plus an independent bias register.
module wmem_stream
  import wmem_pkg::*;
#(
  parameter  int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter  int ROW_NUM       = ROW_NUM_DEF,
  parameter  int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter  int DEPTH         = 1 << ADDR_WIDTH,
  localparam int ROW_WGT_WIDTH = row_width(DATA_WIDTH, ROW_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [ADDR_WIDTH-1:0]    i_wr_addr,
  input  logic [ROW_WGT_WIDTH-1:0] i_wr_data,
  input  logic                     i_bias_wr_en,
  input  logic [ROW_WGT_WIDTH-1:0] i_bias_data,
  input  logic                     i_start,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [ADDR_WIDTH:0]      i_len,
  input  logic                     i_ready,
  output logic [ROW_WGT_WIDTH-1:0] o_rd_data,
  output logic                     o_valid,
  output logic [ROW_WGT_WIDTH-1:0] o_bias,
  output logic                     o_busy,
  output logic                     o_done
);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]      remain_q, remain_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     seen_q, seen_d;
  logic [ROW_WGT_WIDTH-1:0] bias_q, bias_d;
  logic                     rd_en;
  logic [ROW_WGT_WIDTH-1:0] ram_rd;

  wmem_ram #(
    .WIDTH (ROW_WGT_WIDTH),
    .AW    (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (rd_addr_q),
    .o_rd_data (ram_rd)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    remain_d  = remain_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    seen_d    = seen_q;
    rd_en     = 1'b0;
    bias_d    = i_bias_wr_en ? i_bias_data : bias_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            rd_addr_d = i_base_addr;
            remain_d  = i_len;
            state_d   = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A new row may enter the output register when it is empty or being drained.
        rd_en = (remain_q != '0) && (!valid_q || i_ready);
        if (rd_en) begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          remain_d  = remain_q - (ADDR_WIDTH + 1)'(1);
          valid_d   = 1'b1;
          seen_d    = 1'b1;
          if (remain_q == (ADDR_WIDTH + 1)'(1)) state_d = ST_FLUSH;
        end else if (valid_q && i_ready) begin
          valid_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      remain_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
      bias_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      remain_q  <= remain_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      seen_q    <= seen_d;
      bias_q    <= bias_d;
    end
  end

  // The RAM output register has no reset, so it is masked until a read lands.
  assign o_rd_data = seen_q ? ram_rd : '0;
  assign o_valid   = valid_q;
  assign o_bias    = bias_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;

endmodule

// File: doc/wmem_stream.md
Name: wmem_stream

Overview:
- Parametrised weight memory that replaces the 4-entry fake weight store with a full-depth array and a streaming read sequencer.
- The loader writes rows and the bias word. The PE array then requests a burst of consecutive rows (base, length) and consumes them over a valid/ready handshake with back-pressure.
- Sits between the weight loader/DMA and the row-parallel PE array.

Parameters:
- DATA_WIDTH, 8, bits per weight
- ROW_NUM, 6, weights per row
- ADDR_WIDTH, 7, row address width
- DEPTH, 1<<ADDR_WIDTH, number of rows in the array
- ROW_WGT_WIDTH, DATA_WIDTH*ROW_NUM, row width (derived, not overridden)

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, asynchronous active-high reset
- i_wr_en, in, 1, row write strobe
- i_wr_addr, in, ADDR_WIDTH, row write address
- i_wr_data, in, ROW_WGT_WIDTH, row write data
- i_bias_wr_en, in, 1, bias register write strobe
- i_bias_data, in, ROW_WGT_WIDTH, bias write data
- i_start, in, 1, start burst (sampled only in IDLE)
- i_base_addr, in, ADDR_WIDTH, first row of burst
- i_len, in, ADDR_WIDTH+1, rows in burst (0..2*DEPTH-1)
- i_ready, in, 1, consumer accepts o_rd_data
- o_rd_data, out, ROW_WGT_WIDTH, streamed row
- o_valid, out, 1, o_rd_data valid
- o_bias, out, ROW_WGT_WIDTH, registered bias
- o_busy, out, 1, burst in progress
- o_done, out, 1, one-cycle pulse at burst end

Behaviour:
- Reset values: o_valid=0, o_busy=0, o_done=0, o_bias=0, o_rd_data=0, FSM=IDLE, address and count registers 0. RAM contents are not reset; they are preserved across reset and undefined until written.
- Writes: on i_wr_en, RAM[i_wr_addr] <= i_wr_data at the clock edge. Writes are legal in any state.
- Bias: on i_bias_wr_en, o_bias <= i_bias_data. It is independent of the RAM and the FSM.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - i_start with i_len!=0: latch rd_addr=i_base_addr and remaining=i_len, then go to RUN; o_busy=1 from the next cycle.
  - i_start with i_len==0: o_done=1 the next cycle, stay IDLE, no beats emitted.
- RUN, read issue:
  - A read issues when remaining!=0 and (!o_valid || i_ready).
  - On issue: o_rd_data <= RAM[rd_addr], o_valid <= 1, rd_addr increments modulo DEPTH (wraps DEPTH-1 -> 0), remaining decrements.
  - Read latency is 1 cycle. The first o_valid appears 2 cycles after the i_start edge.
- RUN, back-pressure: when o_valid && !i_ready, o_rd_data and o_valid hold and no read issues.
- RUN, handshake: a beat transfers when o_valid && i_ready. With i_ready held high, one beat per cycle.
- RUN -> FLUSH when the last read issues (remaining goes 1 -> 0).
- FLUSH: wait for the final beat to be accepted. On acceptance: o_valid <= 0, o_done pulses one cycle, o_busy <= 0, return to IDLE.
- i_start while o_busy is ignored; the latched parameters are unchanged.
- Read/write collision on the same address in the same cycle: the read returns the old data (read-before-write).
- Reset mid-burst: immediate return to IDLE with all outputs at reset values; an in-flight beat is discarded.
- o_rd_data holds its last value while idle; only o_valid qualifies it.

Decomposition:
- Shared package wmem_pkg:
  - state enum {IDLE, RUN, FLUSH}
  - default DATA_WIDTH/ROW_NUM/ADDR_WIDTH constants
  - ROW_WGT_WIDTH derivation
- One sub-module, wmem_ram: simple dual-port RAM with synchronous read (write port plus read-enable port, read-before-write, no reset).
- Sequencer, bias register and handshake live in wmem_stream.

Test Plan:
- Write rows 0..7 with data=addr*0x010101010101, start base=2 len=4, i_ready=1 -> o_valid high 4 consecutive cycles carrying rows 2,3,4,5; o_done pulses the cycle after row 5 is accepted.
- Wrap: with DEPTH=128, start base=126 len=4 -> rows 126,127,0,1 in order.
- Back-pressure: len=3, i_ready toggled 1,0,0,1,1 -> each row held stable while stalled, no row skipped or duplicated, exactly 3 transfers.
- len=0 -> no o_valid, o_busy stays 0, o_done pulses 1 cycle. i_start during a burst -> ignored, burst length unchanged.
- Collision: write 0xAA.. to row 3 in the cycle row 3 is read -> old value streamed; a later burst returns 0xAA...
- Bias written to 0x123456789ABC, then i_rst asserted mid-burst -> o_valid/o_busy/o_bias drop to 0 asynchronously; RAM rows are still readable afterwards.
